booth_mul_seq: RTL

Iterative radix-8 Booth multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It sits directly upstream of the Booth partial-product stage. The block owns operand extension, the 4-bit `sel` window generation, the shift-and-accumulate datapath and the execute-stage handshake. Each cycle it retires one 3-bit multiplier group, using the same `sel` encoding as `booth_decode`.

---
 rtl/booth_mul_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-8 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Retires one 3-bit multiplier group per cycle (12 groups), then holds the
// selected half of the 64-bit product until the consumer takes it.
module booth_mul_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [TAG_W-1:0]      tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_W-1:0]      tag_out
);

  localparam logic [3:0] LAST_K = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [1:0]      r_op;
  logic [3:0]      r_k;
  logic [32:0]     r_x;        // multiplicand, extended to 33 bits
  logic [35:0]     r_y;        // multiplier, extended to 36 bits
  // Only the low 64 bits of the accumulator ever reach the result, so the
  // accumulator is kept mod 2^64; the low 64 bits match a 72-bit sum exactly.
  logic [63:0]     r_acc;
  logic            r_out_valid;
  logic [31:0]     r_result;
  logic [TAG_W-1:0] r_tag_out;

  logic [32:0]     w_x_ext;
  logic [35:0]     w_y_ext;
  logic [36:0]     w_y_win;    // {Y, Y[-1]=0}
  logic [5:0]      w_base;     // 3*k, bit offset of the current group
  logic [3:0]      w_sel;
  logic [35:0]     w_x1;
  logic [35:0]     w_x2;
  logic [35:0]     w_x3;
  logic [35:0]     w_x4;
  logic [35:0]     w_pp;
  logic [63:0]     w_pp64;
  logic [63:0]     w_acc_next;
  logic [31:0]     w_result_sel;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign tag_out   = r_tag_out;

  // Operand extension at accept: MULHU treats rs1 as unsigned, MULHSU/MULHU treat rs2 as unsigned.
  assign w_x_ext = {(op != 2'b11) & a[31], a};
  assign w_y_ext = {{4{~op[1] & b[31]}}, b};

  // Booth window for group k: {Y[3k+2], Y[3k+1], Y[3k], Y[3k-1]}.
  assign w_y_win = {r_y, 1'b0};
  assign w_base  = {2'b00, r_k} * 6'd3;
  assign w_sel   = w_y_win[w_base +: 4];

  // Multiples of the sign-extended multiplicand; 36 bits hold +/-4*2^32 without overflow.
  assign w_x1 = {{3{r_x[32]}}, r_x};
  assign w_x2 = w_x1 << 1;
  assign w_x3 = w_x1 + w_x2;
  assign w_x4 = w_x1 << 2;

  // Partial product selection from the sel code (same encoding as booth_decode).
  always_comb begin
    w_pp = '0;
    case (w_sel)
      4'd1, 4'd2:   w_pp = w_x1;
      4'd3, 4'd4:   w_pp = w_x2;
      4'd5, 4'd6:   w_pp = w_x3;
      4'd7:         w_pp = w_x4;
      4'd8:         w_pp = -w_x4;
      4'd9, 4'd10:  w_pp = -w_x3;
      4'd11, 4'd12: w_pp = -w_x2;
      4'd13, 4'd14: w_pp = -w_x1;
      default:      w_pp = '0;
    endcase
  end

  assign w_pp64       = {{28{w_pp[35]}}, w_pp};
  assign w_acc_next   = r_acc + (w_pp64 << w_base);
  assign w_result_sel = (r_op == 2'b00) ? w_acc_next[31:0] : w_acc_next[63:32];

  // Next-state decode; flush overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_BUSY;
      S_BUSY:  if (r_k == LAST_K) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  // State register and output-valid flag; out_valid tracks entry into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (w_state_next == S_DONE);
    end
  end

  // Datapath: capture operands on accept, accumulate one group per BUSY cycle,
  // register the selected product half on the last group.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= 2'b00;
      r_k       <= 4'd0;
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_tag_out <= '0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op      <= op;
            r_tag_out <= tag_in;
            r_x       <= w_x_ext;
            r_y       <= w_y_ext;
            r_acc     <= '0;
            r_k       <= 4'd0;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 4'd1;
          if (r_k == LAST_K) r_result <= w_result_sel;
        end
        default: ;
      endcase
    end
  end

endmodule
